// File: rtl/fib_sequence_locator.sv
// Walks the Fibonacci sequence one term per clock to locate an operand:
// reports membership, index and the bracketing terms, or range overflow.
module fib_sequence_locator #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_number,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_fib,
  output logic [IDX_W-1:0] fib_index,
  output logic [WIDTH-1:0] fib_lower,
  output logic [WIDTH-1:0] fib_upper,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   num_q, num_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     b_q, b_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               is_fib_q, is_fib_d;
  logic [IDX_W-1:0]   fib_index_q, fib_index_d;
  logic [WIDTH-1:0]   fib_lower_q, fib_lower_d;
  logic [WIDTH-1:0]   fib_upper_q, fib_upper_d;
  logic               overflow_q, overflow_d;

  // Next term with its carry kept, so leaving the representable range is visible.
  function automatic logic [WIDTH:0] fib_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Upper bracket when the sequence runs out of range: saturate to all-ones.
  function automatic logic [WIDTH-1:0] sat_upper();
    return {WIDTH{1'b1}};
  endfunction

  assign in_ready  = (state_q == IDLE) && enable;
  assign out_valid = (state_q == DONE);
  assign is_fib    = is_fib_q;
  assign fib_index = fib_index_q;
  assign fib_lower = fib_lower_q;
  assign fib_upper = fib_upper_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    a_d         = a_q;
    b_d         = b_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    is_fib_d    = is_fib_q;
    fib_index_d = fib_index_q;
    fib_lower_d = fib_lower_q;
    fib_upper_d = fib_upper_q;
    overflow_d  = overflow_q;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            num_d   = in_number;
            a_d     = '0;
            b_d     = (WIDTH+1)'(1);
            prev_d  = '0;
            idx_d   = '0;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (a_q == num_q) begin
            is_fib_d    = 1'b1;
            fib_index_d = idx_q;
            fib_lower_d = a_q;
            fib_upper_d = a_q;
            overflow_d  = 1'b0;
            state_d     = DONE;
          end else if (a_q > num_q) begin
            // Overshot: the previous term is the lower bracket.
            is_fib_d    = 1'b0;
            fib_index_d = idx_q - IDX_W'(1);
            fib_lower_d = prev_q;
            fib_upper_d = a_q;
            overflow_d  = 1'b0;
            state_d     = DONE;
          end else if (b_q[WIDTH]) begin
            is_fib_d    = 1'b0;
            fib_index_d = idx_q;
            fib_lower_d = a_q;
            fib_upper_d = sat_upper();
            overflow_d  = 1'b1;
            state_d     = DONE;
          end else begin
            prev_d = a_q;
            a_d    = b_q[WIDTH-1:0];
            b_d    = fib_add(a_q, b_q[WIDTH-1:0]);
            idx_d  = idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= (WIDTH+1)'(1);
      prev_q      <= '0;
      idx_q       <= '0;
      is_fib_q    <= 1'b0;
      fib_index_q <= '0;
      fib_lower_q <= '0;
      fib_upper_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      is_fib_q    <= is_fib_d;
      fib_index_q <= fib_index_d;
      fib_lower_q <= fib_lower_d;
      fib_upper_q <= fib_upper_d;
      overflow_q  <= overflow_d;
    end
  end

  // Operand is captured only on acceptance and needs no reset value.
  always_ff @(posedge clock) begin
    num_q <= num_d;
  end

endmodule

// File: tb/tb_fib_sequence_locator.sv
// Directed bench for fib_sequence_locator (WIDTH=32): latency, results,
// back-pressure, enable abort and asynchronous reset.
module tb_fib_sequence_locator;

  localparam int WIDTH = 32;
  localparam int IDX_W = 7;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] in_number;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             is_fib;
  logic [IDX_W-1:0] fib_index;
  logic [WIDTH-1:0] fib_lower;
  logic [WIDTH-1:0] fib_upper;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  fib_sequence_locator #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_number (in_number),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .is_fib    (is_fib),
    .fib_index (fib_index),
    .fib_lower (fib_lower),
    .fib_upper (fib_upper),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an operand, wait for the result, check latency and all result fields,
  // optionally hold the result under back-pressure, then consume it.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] num, input int exp_lat,
                        input logic exp_fib, input logic [IDX_W-1:0] exp_idx,
                        input logic [WIDTH-1:0] exp_lo, input logic [WIDTH-1:0] exp_hi,
                        input logic exp_ovf, input int hold);
    int cycles;
    @(negedge clock);
    in_number = num;
    in_valid  = 1'b1;
    check_eq({tag, ".in_ready"}, in_ready, 1'b1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    check_eq({tag, ".latency"}, cycles, exp_lat);
    check_eq({tag, ".is_fib"}, is_fib, exp_fib);
    check_eq({tag, ".index"}, fib_index, exp_idx);
    check_eq({tag, ".lower"}, fib_lower, exp_lo);
    check_eq({tag, ".upper"}, fib_upper, exp_hi);
    check_eq({tag, ".overflow"}, overflow, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check_eq({tag, ".hold_valid"}, out_valid, 1'b1);
      check_eq({tag, ".hold_ready"}, in_ready, 1'b0);
      check_eq({tag, ".hold_lower"}, fib_lower, exp_lo);
      check_eq({tag, ".hold_index"}, fib_index, exp_idx);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".consumed_valid"}, out_valid, 1'b0);
    check_eq({tag, ".ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    int seen_valid;
    reset     = 1'b1;
    enable    = 1'b1;
    in_number = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst.out_valid", out_valid, 1'b0);
    check_eq("rst.is_fib", is_fib, 1'b0);
    check_eq("rst.index", fib_index, 0);
    check_eq("rst.lower", fib_lower, 0);
    check_eq("rst.upper", fib_upper, 0);
    check_eq("rst.overflow", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst.in_ready", in_ready, 1'b1);

    run_op("zero",  32'd0,          1,  1'b1, 7'd0,  32'd0,          32'd0,          1'b0, 0);
    run_op("thirteen", 32'd13,      8,  1'b1, 7'd7,  32'd13,         32'd13,         1'b0, 0);
    run_op("four",  32'd4,          6,  1'b0, 7'd4,  32'd3,          32'd5,          1'b0, 5);
    run_op("allones", 32'hFFFFFFFF, 48, 1'b0, 7'd47, 32'd2971215073, 32'hFFFFFFFF,   1'b1, 0);
    run_op("f47",   32'd2971215073, 48, 1'b1, 7'd47, 32'd2971215073, 32'd2971215073, 1'b0, 0);
    run_op("k1000", 32'd1000,       18, 1'b0, 7'd16, 32'd987,        32'd1597,       1'b0, 0);

    // Abort a search for 1000 by dropping enable three cycles in.
    @(negedge clock);
    in_number = 32'd1000;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    check_eq("abort.in_ready", in_ready, 1'b0);
    check_eq("abort.out_valid", out_valid, 1'b0);
    seen_valid = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (out_valid) seen_valid++;
    end
    check_eq("abort.never_valid", seen_valid, 0);
    check_eq("abort.lower_kept", fib_lower, 32'd987);
    @(negedge clock);
    enable = 1'b1;
    #1;
    check_eq("abort.ready_back", in_ready, 1'b1);
    repeat (25) begin
      @(posedge clock);
      #1;
      if (out_valid) seen_valid++;
    end
    check_eq("abort.still_idle", seen_valid, 0);

    // Asynchronous reset in the middle of a search.
    @(negedge clock);
    in_number = 32'd100;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst.out_valid", out_valid, 1'b0);
    check_eq("mid_rst.is_fib", is_fib, 1'b0);
    check_eq("mid_rst.index", fib_index, 0);
    check_eq("mid_rst.lower", fib_lower, 0);
    check_eq("mid_rst.upper", fib_upper, 0);
    check_eq("mid_rst.overflow", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    run_op("one", 32'd1, 2, 1'b1, 7'd1, 32'd1, 32'd1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
